// File: rtl/node_port_pkg.sv
// Shared link types for the node/router byte-serial port: packet layout and FSM encodings.
package RouterPkg;

    localparam int unsigned PKT_BYTES = 4;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic [2:0] {TX_IDLE, TX_B0, TX_B1, TX_B2, TX_B3} txst_t;
    typedef enum logic [1:0] {RX_IDLE, RX_B1, RX_B2, RX_B3} rxst_t;

    // Byte idx of the link image, byte 0 being the most significant.
    function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
        logic [31:0] w;
        w = p;
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/node_port_tx_fifo.sv
// TX packet FIFO for node_port: power-of-two depth; a push while full is accepted when a pop
// happens in the same cycle.
module node_tx_fifo
    import RouterPkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  pkt_t        wdata_i,
    output pkt_t        rdata_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] level_o
);

    pkt_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q;
    logic          do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/node_port.sv
// Node-side router link endpoint: TX FIFO + byte serializer, RX byte deserializer + holding register.
// Optional NODE_PORT_STATS_EN adds saturating packet counters and a TX source-id check into err_rx.
module node_port
    import RouterPkg::*;
#(
    parameter int unsigned NODEID   = 0,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] tx_pkt,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_pkt,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic        free_inbound,
    output logic        put_inbound,
    output logic [7:0]  payload_inbound,
    output logic        free_outbound,
    input  logic        put_outbound,
    input  logic [7:0]  payload_outbound,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic        err_rx
);

    localparam int unsigned AW = $clog2(TX_DEPTH);
    localparam int unsigned SW = (PKT_BYTES - 1) * 8;

    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 || NODEID > 15) begin : g_param_check
        $error("node_port: TX_DEPTH must be a power of 2 >= 2 and NODEID must fit 4 bits");
    end

    txst_t       tx_state_q, tx_state_d;
    pkt_t        head;
    logic        fifo_full, fifo_empty, push, pop, more_queued, src_err;
    logic [AW:0] fifo_level;

    assign pop         = (tx_state_q == TX_B3);
    assign push        = tx_valid & tx_ready;
    // A full FIFO still takes a push in the cycle byte 3 pops its head.
    assign tx_ready    = ~fifo_full | pop;
    assign more_queued = (fifo_level > (AW+1)'(1));

    node_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (pkt_t'(tx_pkt)),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) tx_state_q <= TX_IDLE;
        else          tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TX_IDLE: if (!fifo_empty && free_inbound) tx_state_d = TX_B0;
            TX_B0:   tx_state_d = TX_B1;
            TX_B1:   tx_state_d = TX_B2;
            TX_B2:   tx_state_d = TX_B3;
            TX_B3:   tx_state_d = (more_queued && free_inbound) ? TX_B0 : TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        put_inbound     = 1'b0;
        payload_inbound = '0;
        unique case (tx_state_q)
            TX_B0:   begin put_inbound = 1'b1; payload_inbound = pkt_byte(head, 2'd0); end
            TX_B1:   begin put_inbound = 1'b1; payload_inbound = pkt_byte(head, 2'd1); end
            TX_B2:   begin put_inbound = 1'b1; payload_inbound = pkt_byte(head, 2'd2); end
            TX_B3:   begin put_inbound = 1'b1; payload_inbound = pkt_byte(head, 2'd3); end
            default: ;
        endcase
    end

    rxst_t         rx_state_q, rx_state_d;
    logic [SW-1:0] shift_q;
    pkt_t          hold_q;
    logic          rx_valid_q, rx_valid_d, free_q, drop_q, drop_d, err_q, err_d;
    logic          rx_abort, rx_done, rx_overrun, rx_load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rx_state_q <= RX_IDLE;
        else          rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = RX_IDLE;
        unique case (rx_state_q)
            RX_IDLE: rx_state_d = put_outbound ? RX_B1 : RX_IDLE;
            RX_B1:   rx_state_d = put_outbound ? RX_B2 : RX_IDLE;
            RX_B2:   rx_state_d = put_outbound ? RX_B3 : RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_abort   = (rx_state_q != RX_IDLE) && !put_outbound;
        rx_done    = (rx_state_q == RX_B3) && put_outbound;
        rx_overrun = (rx_state_q == RX_IDLE) && put_outbound && rx_valid_q;
        rx_load    = rx_done && !drop_q;
        // Overrun is decided at byte 0; the rest of that packet is received and discarded.
        drop_d     = ((rx_state_q == RX_IDLE) && put_outbound) ? rx_valid_q : drop_q;
        rx_valid_d = rx_load ? 1'b1 : (rx_valid_q && rx_ready) ? 1'b0 : rx_valid_q;
        err_d      = err_q | rx_abort | rx_overrun | src_err;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q    <= '0;
            hold_q     <= '0;
            rx_valid_q <= 1'b0;
            free_q     <= 1'b1;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (put_outbound) shift_q <= {shift_q[SW-9:0], payload_outbound};
            if (rx_load)      hold_q  <= {shift_q, payload_outbound};
            rx_valid_q <= rx_valid_d;
            free_q     <= ~rx_valid_q;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    assign rx_pkt        = hold_q;
    assign rx_valid      = rx_valid_q;
    assign free_outbound = free_q;
    assign err_rx        = err_q;

`ifdef NODE_PORT_STATS_EN
    localparam logic [3:0] NODE_SRC = 4'(NODEID);
    logic [15:0] tx_cnt_q, rx_cnt_q;

    assign src_err = pop && (head.src != NODE_SRC);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (pop && tx_cnt_q != '1)     tx_cnt_q <= tx_cnt_q + 16'd1;
            if (rx_load && rx_cnt_q != '1) rx_cnt_q <= rx_cnt_q + 16'd1;
        end
    end

    assign tx_count = tx_cnt_q;
    assign rx_count = rx_cnt_q;
`else
    assign src_err  = 1'b0;
    assign tx_count = '0;
    assign rx_count = '0;
`endif

endmodule

// File: tb/tb_node_port.sv
// Self-checking bench for node_port: TX serialization/back-pressure/FIFO-full, RX table, overrun, reset.
`timescale 1ns/1ps
module tb_node_port;
    import RouterPkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] tx_pkt = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_pkt;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        free_inbound = 1'b0;
    logic        put_inbound;
    logic [7:0]  payload_inbound;
    logic        free_outbound;
    logic        put_outbound = 1'b0;
    logic [7:0]  payload_outbound = '0;
    logic [15:0] tx_count, rx_count;
    logic        err_rx;

    node_port #(.NODEID(0), .TX_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .tx_pkt           (tx_pkt),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_pkt           (rx_pkt),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .free_inbound     (free_inbound),
        .put_inbound      (put_inbound),
        .payload_inbound  (payload_inbound),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .tx_count         (tx_count),
        .rx_count         (rx_count),
        .err_rx           (err_rx)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0]  tx_exp_q [$];
    logic [31:0] rx_exp_q [$];
    int put_total = 0, win_first = -1, win_last = -1, push_cyc = 0;
    int tx_byte_idx = 0, model_tx_cnt = 0, model_rx_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int m);
`ifdef NODE_PORT_STATS_EN
        return (m > 65535) ? 32'h0000_FFFF : 32'(m);
`else
        return (m < 0) ? 32'h1 : 32'h0;
`endif
    endfunction

    // Link and core-side monitors compare against the scoreboard queues.
    always @(negedge clock) begin
        if (reset_n) begin
            if (put_inbound) begin
                put_total++;
                if (win_first < 0) win_first = cyc;
                win_last = cyc;
                if (tx_exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL tx_byte: got %02h, expected no byte on the link", payload_inbound);
                end else begin
                    check("tx_byte", {24'h0, payload_inbound}, {24'h0, tx_exp_q.pop_front()});
                end
                tx_byte_idx = (tx_byte_idx + 1) % 4;
                if (tx_byte_idx == 0) model_tx_cnt++;
            end else begin
                check("tx_idle_payload", {24'h0, payload_inbound}, 32'h0);
            end
            if (rx_valid && rx_ready) begin
                if (rx_exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rx_pkt: got %08h, expected no packet", rx_pkt);
                end else begin
                    check("rx_pkt", rx_pkt, rx_exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic push_tx(input logic [31:0] p);
        bit done;
        done     = 1'b0;
        tx_pkt   = p;
        tx_valid = 1'b1;
        for (int unsigned i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (tx_ready) begin
                for (int unsigned b = 0; b < 4; b++) tx_exp_q.push_back(p[31-8*b -: 8]);
                push_cyc = cyc + 1;
                done     = 1'b1;
            end
        end
        tick();
        tx_valid = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL tx_push_timeout: tx_ready stayed 0, expected 1");
        end
    endtask

    task automatic send_rx(input logic [31:0] p, input int unsigned nbytes, input bit expect_load);
        if (expect_load) begin
            rx_exp_q.push_back(p);
            model_rx_cnt++;
        end
        for (int unsigned b = 0; b < nbytes; b++) begin
            put_outbound     = 1'b1;
            payload_outbound = p[31-8*b -: 8];
            tick();
        end
        put_outbound     = 1'b0;
        payload_outbound = '0;
    endtask

    task automatic flush_and_release();
        tx_exp_q.delete();
        rx_exp_q.delete();
        tx_byte_idx  = 0;
        model_tx_cnt = 0;
        model_rx_cnt = 0;
        reset_n      = 1'b1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        tx_valid     = 1'b0;
        rx_ready     = 1'b0;
        put_outbound = 1'b0;
        free_inbound = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        flush_and_release();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_put_inbound"},   {31'h0, put_inbound},   32'h0);
        check({tag, "_payload"},       {24'h0, payload_inbound}, 32'h0);
        check({tag, "_tx_ready"},      {31'h0, tx_ready},      32'h1);
        check({tag, "_free_outbound"}, {31'h0, free_outbound}, 32'h1);
        check({tag, "_rx_valid"},      {31'h0, rx_valid},      32'h0);
        check({tag, "_rx_pkt"},        rx_pkt,                 32'h0);
        check({tag, "_err_rx"},        {31'h0, err_rx},        32'h0);
        check({tag, "_tx_count"},      {16'h0, tx_count},      32'h0);
        check({tag, "_rx_count"},      {16'h0, rx_count},      32'h0);
    endtask

    typedef struct {
        logic [31:0] pkt;
        int unsigned nbytes;
        bit          exp_valid;
        bit          exp_err;
    } rx_vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rx_vec_t vecs [6];
        int base;
        bit hit;

        vecs[0] = '{32'hABCD_EF01, 4, 1'b1, 1'b0};
        vecs[1] = '{32'h1122_3344, 2, 1'b0, 1'b1};
        vecs[2] = '{32'hCAFE_BABE, 4, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_0000, 1, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 3, 1'b0, 1'b1};
        vecs[5] = '{32'h5A5A_A5A5, 4, 1'b1, 1'b1};

        #1 reset_n = 1'b0;
        #3 check_idle_outputs("reset");
        do_reset();

        // Single packet: 1-cycle latency, 4 bytes MSB first, then idle.
        free_inbound = 1'b1;
        win_first = -1;
        base = put_total;
        push_tx(32'h1234_5678);
        repeat (8) tick();
        check("t1_latency",   32'(win_first - push_cyc), 32'd1);
        check("t1_put_cycles", 32'(put_total - base),    32'd4);
        check("t1_contiguous", 32'(win_last - win_first), 32'd3);
        check("t1_put_after",  {31'h0, put_inbound},     32'h0);
        check("t1_drained",    32'(tx_exp_q.size()),     32'd0);

        // Back-pressure then back-to-back release.
        free_inbound = 1'b0;
        win_first = -1;
        base = put_total;
        push_tx(32'hAABB_CCDD);
        push_tx(32'h0F1E_2D3C);
        repeat (10) tick();
        check("t2_no_put_blocked", 32'(put_total - base), 32'd0);
        free_inbound = 1'b1;
        repeat (14) tick();
        check("t2_put_cycles",  32'(put_total - base),     32'd8);
        check("t2_back2back",   32'(win_last - win_first), 32'd7);
        check("t2_drained",     32'(tx_exp_q.size()),      32'd0);

        // FIFO full, then push accepted in the pop cycle keeps it full.
        free_inbound = 1'b0;
        base = put_total;
        for (int unsigned i = 0; i < DEPTH; i++) push_tx(32'h0100_0000 + 32'(i));
        check("t5_full_ready", {31'h0, tx_ready}, 32'h0);
        free_inbound = 1'b1;
        push_tx(32'h0200_00AA);
        free_inbound = 1'b0;
        check("t5_still_full", {31'h0, tx_ready}, 32'h0);
        tick();
        check("t5_still_full2", {31'h0, tx_ready}, 32'h0);
        free_inbound = 1'b1;
        repeat (24) tick();
        check("t5_put_cycles", 32'(put_total - base), 32'd20);
        check("t5_drained",    32'(tx_exp_q.size()),  32'd0);
        check("tx_count_stats", {16'h0, tx_count}, exp_cnt(model_tx_cnt));
`ifdef NODE_PORT_STATS_EN
        check("src_err", {31'h0, err_rx}, 32'h1);
`else
        check("src_err", {31'h0, err_rx}, 32'h0);
`endif

        // Reset while byte 2 is on the link.
        free_inbound = 1'b1;
        push_tx(32'h9876_5432);
        hit = 1'b0;
        for (int unsigned i = 0; i < 20 && !hit; i++) begin
            @(negedge clock);
            if (put_inbound && payload_inbound == 8'h54) hit = 1'b1;
        end
        if (!hit) begin
            n_tests++; n_fail++;
            $display("FAIL t6_byte2_timeout: byte 2 not seen, expected 54");
        end
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_put",   {31'h0, put_inbound}, 32'h0);
        check("t6_async_ready", {31'h0, tx_ready},    32'h1);
        free_inbound = 1'b0;
        repeat (2) @(posedge clock);
        #1 flush_and_release();
        tick();
        check_idle_outputs("t6_after");

        // RX vectors: full packets, truncations, sticky error.
        for (int unsigned v = 0; v < 6; v++) begin
            send_rx(vecs[v].pkt, vecs[v].nbytes, vecs[v].exp_valid);
            tick();
            check("rx_valid", {31'h0, rx_valid},       {31'h0, vecs[v].exp_valid});
            check("rx_err",   {31'h0, err_rx},         {31'h0, vecs[v].exp_err});
            check("rx_free",  {31'h0, free_outbound},  {31'h0, !vecs[v].exp_valid});
            if (vecs[v].exp_valid) begin
                tick();
                check("rx_free_held", {31'h0, free_outbound}, 32'h0);
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
                check("rx_consumed", {31'h0, rx_valid}, 32'h0);
                tick();
                check("rx_free_back", {31'h0, free_outbound}, 32'h1);
            end
        end

        // Overrun: second packet while the first is still held is dropped.
        do_reset();
        send_rx(32'h3C3C_0F0F, 4, 1'b1);
        check("ovr_err_before", {31'h0, err_rx}, 32'h0);
        send_rx(32'h7777_8888, 4, 1'b0);
        tick();
        check("ovr_err",   {31'h0, err_rx},   32'h1);
        check("ovr_valid", {31'h0, rx_valid}, 32'h1);
        check("ovr_kept",  rx_pkt,            32'h3C3C_0F0F);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        send_rx(32'hDEAD_0042, 4, 1'b1);
        tick();
        check("ovr_next_valid", {31'h0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        check("rx_count_stats", {16'h0, rx_count}, exp_cnt(model_rx_cnt));
        check("tx_count_zero",  {16'h0, tx_count}, 32'h0);
        check("rx_sb_empty",    32'(rx_exp_q.size()), 32'd0);
        check("tx_sb_empty",    32'(tx_exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
